mc_datapath_hs: RTL

Parametrised next-generation multicycle RISC-V datapath. It keeps the PC / OldPC / IR / MDR / A / WD / ALUOut register structure and external-controller interface. It adds a valid/ready memory handshake with stall, byte-lane load/store alignment, a wider ALU op set with branch-compare flags, and U/J immediates. It sits between the multicycle controller FSM and the unified instruction/data memory.

---
 rtl/mc_datapath_hs_if.sv | 21 ++
 rtl/mc_datapath_hs.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_hs_if.sv
// rtl/mc_datapath_hs_if.sv - unified instruction/data memory handshake bundle
interface mc_datapath_hs_if #(
    parameter int XLEN = 32
);
    logic                mem_valid;
    logic                mem_ready;
    logic [XLEN-1:0]     Addr;
    logic [XLEN-1:0]     WriteData;
    logic [XLEN/8-1:0]   ByteEn;
    logic [XLEN-1:0]     ReadData;

    modport master (
        output mem_valid, Addr, WriteData, ByteEn,
        input  mem_ready, ReadData
    );

    modport slave (
        input  mem_valid, Addr, WriteData, ByteEn,
        output mem_ready, ReadData
    );
endinterface

// File: rtl/mc_datapath_hs.sv
// rtl/mc_datapath_hs.sv - multicycle RISC-V datapath with stalling memory handshake and lane alignment
module mc_datapath_hs #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    mc_datapath_hs_if.master       mem,
    input  logic [2:0]             ImmSrc,
    input  logic [3:0]             ALUControl,
    input  logic [1:0]             ResultSrc,
    input  logic [1:0]             ALUSrcA,
    input  logic [1:0]             ALUSrcB,
    input  logic                   IRWrite,
    input  logic                   RegWrite,
    input  logic                   PCWrite,
    input  logic                   AddrSrc,
    input  logic                   MemRead,
    input  logic                   MemWrite,
    input  logic [1:0]             Size,
    input  logic                   LoadUnsigned,
    output logic [31:0]            Instr,
    output logic                   zero,
    output logic                   lt,
    output logic                   ltu,
    output logic                   stall
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SHW  = $clog2(XLEN);
    localparam int RW   = $clog2(NREGS);

    logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d, mdr_q, mdr_d;
    logic [XLEN-1:0] a_q, a_d, wd_q, wd_d, alu_out_q, alu_out_d;
    logic [31:0]     instr_q, instr_d;
    logic [OFFW-1:0] ld_off_q, ld_off_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, ld_data, ld_shift, result;
    logic [SHW-1:0]  shamt;
    logic [NB-1:0]   fmask;
    logic            rf_we;

    assign Instr   = instr_q;
    assign rs1_idx = instr_q[15 +: RW];
    assign rs2_idx = instr_q[20 +: RW];
    assign rd_idx  = instr_q[7 +: RW];
    assign rd1     = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    assign rd2     = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];

    always_comb begin
        imm_ext = {XLEN{instr_q[31]}};
        case (ImmSrc)
            3'd0: imm_ext[11:0] = instr_q[31:20];
            3'd1: imm_ext[11:0] = {instr_q[31:25], instr_q[11:7]};
            3'd2: imm_ext[12:0] = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            3'd3: imm_ext[20:0] = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            3'd4: imm_ext[31:0] = {instr_q[31:12], 12'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        case (ALUSrcA)
            2'd0:    src_a = pc_q;
            2'd1:    src_a = old_pc_q;
            2'd2:    src_a = a_q;
            default: src_a = '0;
        endcase
        case (ALUSrcB)
            2'd0:    src_b = wd_q;
            2'd1:    src_b = imm_ext;
            2'd2:    src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    assign shamt = src_b[SHW-1:0];
    assign lt    = $signed(src_a) < $signed(src_b);
    assign ltu   = src_a < src_b;
    assign zero  = (alu_result == '0);

    always_comb begin
        case (ALUControl)
            4'd0:    alu_result = src_a + src_b;
            4'd1:    alu_result = src_a - src_b;
            4'd2:    alu_result = src_a & src_b;
            4'd3:    alu_result = src_a | src_b;
            4'd4:    alu_result = src_a ^ src_b;
            4'd5:    alu_result = {{(XLEN-1){1'b0}}, lt};
            4'd6:    alu_result = {{(XLEN-1){1'b0}}, ltu};
            4'd7:    alu_result = src_a << shamt;
            4'd8:    alu_result = src_a >> shamt;
            4'd9:    alu_result = $signed(src_a) >>> shamt;
            default: alu_result = '0;
        endcase
    end

    // The load offset is captured with MDR so the writeback mux never loops through Addr.
    assign ld_shift = mdr_q >> {ld_off_q, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (Size)
            2'd0: begin
                ld_data      = {XLEN{~LoadUnsigned & ld_shift[7]}};
                ld_data[7:0] = ld_shift[7:0];
            end
            2'd1: begin
                ld_data       = {XLEN{~LoadUnsigned & ld_shift[15]}};
                ld_data[15:0] = ld_shift[15:0];
            end
            2'd2: begin
                ld_data       = {XLEN{~LoadUnsigned & ld_shift[31]}};
                ld_data[31:0] = ld_shift[31:0];
            end
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        case (ResultSrc)
            2'd0:    result = alu_out_q;
            2'd1:    result = ld_data;
            2'd2:    result = alu_result;
            default: result = imm_ext;
        endcase
    end

    assign mem.Addr      = AddrSrc ? result : pc_q;
    assign mem.mem_valid = IRWrite | MemRead | MemWrite;
    assign stall         = mem.mem_valid & ~mem.mem_ready;

    always_comb begin
        case (Size)
            2'd0: begin
                mem.WriteData = {NB{wd_q[7:0]}};
                fmask         = NB'(1);
            end
            2'd1: begin
                mem.WriteData = {(NB/2){wd_q[15:0]}};
                fmask         = NB'(2'b11);
            end
            2'd2: begin
                mem.WriteData = {(NB/4){wd_q[31:0]}};
                fmask         = NB'(4'b1111);
            end
            default: begin
                mem.WriteData = wd_q;
                fmask         = '1;
            end
        endcase
    end

    // Lanes shifted past the top of the word fall off; misalignment is the controller's problem.
    assign mem.ByteEn = MemWrite ? (fmask << mem.Addr[OFFW-1:0]) : '0;

    always_comb begin
        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        ld_off_d  = ld_off_q;
        a_d       = a_q;
        wd_d      = wd_q;
        alu_out_d = alu_out_q;
        if (!stall) begin
            a_d       = rd1;
            wd_d      = rd2;
            alu_out_d = alu_result;
            if (PCWrite)
                pc_d = result;
            if (MemRead && mem.mem_ready) begin
                mdr_d    = mem.ReadData;
                ld_off_d = mem.Addr[OFFW-1:0];
            end
            if (IRWrite && mem.mem_ready) begin
                instr_d  = mem.ReadData[31:0];
                old_pc_d = pc_q;
            end
        end
    end

    assign rf_we = RegWrite & ~stall & (rd_idx != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= '0;
            instr_q   <= '0;
            mdr_q     <= '0;
            ld_off_q  <= '0;
            a_q       <= '0;
            wd_q      <= '0;
            alu_out_q <= '0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            ld_off_q  <= ld_off_d;
            a_q       <= a_d;
            wd_q      <= wd_d;
            alu_out_q <= alu_out_d;
            if (rf_we)
                regs_q[rd_idx] <= result;
        end
    end
endmodule
